udp_tx_framer: RTL
==================

// Module: udp_tx_framer
// PURPOSE
//  Transmit-side counterpart of the UDP receive parser. Accepts a reply burst {dst_ip[4], dst_port[2], payload[N]}
//  and buffers it. Emits a complete Ethernet/IPv4/UDP frame byte stream (dst MAC first, no preamble/FCS) to the MAC.
//  Computes IPv4 header checksum; UDP checksum sent as 0. Pads to 60 bytes.
// PARAMETERS
//  MAX_PAYLOAD  1472   largest N accepted; longer bursts dropped
//  ADDR_W       11     payload buffer address width (2^ADDR_W >= MAX_PAYLOAD)
//  TTL          8'h40  IPv4 TTL
//  IFG          12     idle cycles forced after each frame
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous, active-high reset
//  local_ip       in   32  IPv4 source address
//  local_mac      in   48  Ethernet source address
//  local_port     in   16  UDP source port
//  dst_mac        in   48  Ethernet destination (learned src_mac from rx side)
//  in_data        in   8   request byte
//  in_valid       in   1   high for whole burst, contiguous; burst ends on falling edge
//  tx_data        out  8   frame byte
//  tx_data_valid  out  1   high, contiguous, for every frame byte; no backpressure
//  busy           out  1   high in any state but IDLE
//  drop_cnt       out  16  dropped-burst count, saturating
// BEHAVIOUR
//  Reset (async): state IDLE; tx_data=0, tx_data_valid=0, busy=0, drop_cnt=0, ident=0, byte counters 0.
//  States: IDLE -> RECV -> CSUM -> HDR -> PAY -> PAD -> GAP -> IDLE.
//  IDLE: in_valid rising -> RECV; that byte is byte 0 of the burst.
//  RECV: bytes 0-3 -> dst_ip (MSB first), 4-5 -> dst_port, 6.. written to buffer at addr 0..N-1.
//   On in_valid low: N<0 (burst <6 bytes) or N>MAX_PAYLOAD -> drop, drop_cnt++, -> IDLE. Else latch
//   local_ip/local_mac/local_port/dst_mac, -> CSUM. N=0 is legal.
//  CSUM: 2 cycles. Sum 16-bit words 4500, 28+N, ident, 4000, {TTL,11}, 0000, src ip hi/lo, dst ip hi/lo
//   into 20-bit acc. Fold carries twice, invert. First tx byte on 3rd clk after first in_valid-low cycle.
//  HDR: 42 bytes, offsets: 0-5 dst_mac | 6-11 local_mac | 12-13 0800 | 14 45 | 15 00 | 16-17 28+N | 18-19 ident |
//   20-21 4000 | 22 TTL | 23 11 | 24-25 csum | 26-29 local_ip | 30-33 dst_ip | 34-35 local_port | 36-37 dst_port |
//   38-39 8+N | 40-41 0000. All multi-byte fields MSB first.
//  PAY: N bytes from buffer in order; read address issued one cycle ahead so output has no bubble. N=0 skips PAY.
//  PAD: if 42+N<60, emit 60-(42+N) bytes of 00; else skipped. tx_data_valid stays high across HDR/PAY/PAD.
//  GAP: tx_data_valid=0, tx_data=0 for IFG cycles. ident increments by 1 (16-bit wrap) on entering GAP -> IDLE.
//  in_valid rising in any state except IDLE: whole burst ignored, drop_cnt++ once per burst.
//  in_valid high on GAP->IDLE cycle is mid-burst: ignored, not a rising edge.
//  drop_cnt saturates at FFFF. Reset mid-frame: tx_data_valid falls immediately; frame truncated, no recovery.
// STRUCTURE
//  Shared package/header: ETH_TYPE_IPV4=16'h0800, IP_VER_IHL=8'h45, IP_FLAGS_DF=16'h4000, IP_PROTO_UDP=8'h11,
//   HDR_LEN=42, MIN_FRAME=60, header byte-offset constants. Shared with the rx parser.
//  Sub-module udp_tx_buf: simple dual-port RAM, 2^ADDR_W x 8, 1-cycle registered read.
//  Top contains FSM, checksum datapath, header mux.
// TESTING
//  1 local_ip C0A80101, dst C0A80102, port 1F40->0050, N=18 bytes 01..12 -> 60-byte frame, no pad;
//    bytes16-17=002E, 18-19=0000, 24-25=B76B, 38-39=001A, payload 01..12.
//  2 Same request twice -> 2nd frame ident=0001, checksum B76A; >=IFG idle cycles between frames.
//  3 N=0 (6-byte burst) -> 60-byte frame: total len 001C, udp len 0008, bytes 42-59 = 00.
//  4 Burst of 4 bytes -> no tx, drop_cnt=1. Burst of 6+MAX_PAYLOAD+1 bytes -> no tx, drop_cnt=2.
//  5 New burst starting during HDR of a frame -> current frame unaltered, 2nd burst not sent, drop_cnt+1.
//  6 Assert rst during PAY -> tx_data_valid=0 same cycle; next valid request -> correct frame, ident=0000.

Source files
------------

// File: rtl/udp_tx_framer_pkg.sv
// Shared Ethernet/IPv4/UDP framing constants, header byte offsets, FSM
// states and the IPv4 checksum fold helper. Used by both the tx framer and
// the rx parser.
package udp_tx_framer_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [15:0] IP_FLAGS_DF   = 16'h4000;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;

  localparam int HDR_LEN     = 42;
  localparam int MIN_FRAME   = 60;
  localparam int IP_HDR_LEN  = 20;
  localparam int UDP_HDR_LEN = 8;
  localparam int REQ_HDR_LEN = 6;   // dst_ip[4] + dst_port[2] ahead of payload

  // Header byte offsets from the first byte of the destination MAC
  localparam int OFF_DST_MAC = 0;
  localparam int OFF_SRC_MAC = 6;
  localparam int OFF_ETYPE   = 12;
  localparam int OFF_VER_IHL = 14;
  localparam int OFF_TOS     = 15;
  localparam int OFF_TLEN    = 16;
  localparam int OFF_IDENT   = 18;
  localparam int OFF_FLAGS   = 20;
  localparam int OFF_TTL     = 22;
  localparam int OFF_PROTO   = 23;
  localparam int OFF_CSUM    = 24;
  localparam int OFF_SRC_IP  = 26;
  localparam int OFF_DST_IP  = 30;
  localparam int OFF_SPORT   = 34;
  localparam int OFF_DPORT   = 36;
  localparam int OFF_ULEN    = 38;
  localparam int OFF_UCSUM   = 40;

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_CSUM, S_HDR, S_PAY, S_PAD, S_GAP
  } state_t;

  // Two end-around-carry folds of a 20-bit sum, then one's complement.
  // After the first fold the value is at most 0x1000E, so two are enough.
  function automatic logic [15:0] csum_fold(input logic [19:0] acc);
    logic [16:0] f1;
    logic [15:0] f2;
    f1 = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
    f2 = f1[15:0] + {15'b0, f1[16]};
    return ~f2;
  endfunction

endpackage

// File: rtl/udp_tx_framer_buf.sv
// Payload buffer: simple dual-port RAM, one write port, registered read.
module udp_tx_framer_buf #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // Write port and one-cycle registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/udp_tx_framer.sv
// UDP transmit framer: buffers a {dst_ip, dst_port, payload} burst and emits
// an Ethernet/IPv4/UDP frame (dst MAC first, padded to 60 bytes).
module udp_tx_framer
  import udp_tx_framer_pkg::*;
#(
  parameter int          MAX_PAYLOAD = 1472,
  parameter int          ADDR_W      = 11,
  parameter logic [7:0]  TTL         = 8'h40,
  parameter int          IFG         = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] local_ip,
  input  logic [47:0] local_mac,
  input  logic [15:0] local_port,
  input  logic [47:0] dst_mac,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  localparam int CW = ADDR_W + 1;

  state_t            state, state_nxt;
  logic              in_valid_q, rise, take, len_ok, drop_inc, tx_vld;
  logic [15:0]       rx_cnt, len_q, ident_q, cnt16, pad_len, tlen, ulen;
  logic [CW-1:0]     cnt;
  logic [31:0]       dst_ip_q, src_ip_q;
  logic [15:0]       dst_port_q, src_port_q;
  logic [47:0]       dst_mac_q, src_mac_q;
  logic [19:0]       acc_q;
  logic [15:0]       csum_q;
  logic [7:0]        tx_byte, rd_data;
  logic [5:0]        hdr_idx;
  logic [HDR_LEN*8-1:0] hdr_vec;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  // Only a rising in_valid seen in IDLE starts a burst; anything else is mid-burst
  assign rise    = in_valid & ~in_valid_q;
  assign take    = (state == S_IDLE && rise) || (state == S_RECV && in_valid);
  assign len_ok  = rx_cnt >= 16'(REQ_HDR_LEN) && rx_cnt <= 16'(MAX_PAYLOAD + REQ_HDR_LEN);
  assign cnt16   = 16'(cnt);
  assign pad_len = 16'(MIN_FRAME - HDR_LEN) - len_q;
  assign tlen    = 16'(IP_HDR_LEN + UDP_HDR_LEN) + len_q;
  assign ulen    = 16'(UDP_HDR_LEN) + len_q;
  assign busy    = (state != S_IDLE);
  assign hdr_idx = 6'(HDR_LEN - 1) - cnt[5:0];

  // Header laid out byte 0 in the top bits, so byte i sits at 8*(41-i)
  assign hdr_vec = {dst_mac_q, src_mac_q, ETH_TYPE_IPV4, IP_VER_IHL, 8'h00,
                    tlen, ident_q, IP_FLAGS_DF, TTL, IP_PROTO_UDP, csum_q,
                    src_ip_q, dst_ip_q, src_port_q, dst_port_q, ulen, 16'h0000};

  // Payload write during RECV; read address runs one ahead so PAY has no bubble
  assign wr_en   = take && rx_cnt >= 16'(REQ_HDR_LEN) &&
                   rx_cnt < 16'(MAX_PAYLOAD + REQ_HDR_LEN);
  assign wr_addr = rx_cnt[ADDR_W-1:0] - ADDR_W'(REQ_HDR_LEN);
  assign rd_addr = (state == S_PAY) ? cnt[ADDR_W-1:0] + 1'b1 : '0;

  udp_tx_framer_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, output byte selection and drop detection
  always_comb begin
    state_nxt = state;
    tx_byte   = 8'h00;
    tx_vld    = 1'b0;
    drop_inc  = rise && (state != S_IDLE);
    case (state)
      S_IDLE: if (rise) state_nxt = S_RECV;
      S_RECV: if (!in_valid) begin
        state_nxt = len_ok ? S_CSUM : S_IDLE;
        drop_inc  = !len_ok;
      end
      S_CSUM: if (cnt16 == 16'd1) state_nxt = S_HDR;
      S_HDR: begin
        tx_vld  = 1'b1;
        tx_byte = hdr_vec[{hdr_idx, 3'b000} +: 8];
        if (cnt16 == 16'(HDR_LEN - 1))
          state_nxt = (len_q != 16'd0) ? S_PAY : S_PAD;
      end
      S_PAY: begin
        tx_vld  = 1'b1;
        tx_byte = rd_data;
        if (cnt16 == len_q - 16'd1)
          state_nxt = (len_q < 16'(MIN_FRAME - HDR_LEN)) ? S_PAD : S_GAP;
      end
      S_PAD: begin
        tx_vld = 1'b1;
        if (cnt16 == pad_len - 16'd1) state_nxt = S_GAP;
      end
      S_GAP:   if (cnt16 == 16'(IFG - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state byte/cycle counter, cleared on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       cnt <= '0;
    else if (state_nxt != state || state == S_IDLE) cnt <= '0;
    else                                           cnt <= cnt + 1'b1;
  end

  // Request capture, field latching, checksum, ident and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      rx_cnt     <= '0;
      len_q      <= '0;
      ident_q    <= '0;
      drop_cnt   <= '0;
      dst_ip_q   <= '0;
      dst_port_q <= '0;
      src_ip_q   <= '0;
      src_port_q <= '0;
      src_mac_q  <= '0;
      dst_mac_q  <= '0;
      acc_q      <= '0;
      csum_q     <= '0;
    end else begin
      in_valid_q <= in_valid;
      rx_cnt     <= take ? ((rx_cnt == 16'hFFFF) ? rx_cnt : rx_cnt + 16'd1) : 16'd0;
      if (take && rx_cnt < 16'd4) dst_ip_q   <= {dst_ip_q[23:0], in_data};
      if (take && (rx_cnt == 16'd4 || rx_cnt == 16'd5))
        dst_port_q <= {dst_port_q[7:0], in_data};
      if (state == S_RECV && !in_valid && len_ok) begin
        len_q      <= rx_cnt - 16'(REQ_HDR_LEN);
        src_ip_q   <= local_ip;
        src_mac_q  <= local_mac;
        src_port_q <= local_port;
        dst_mac_q  <= dst_mac;
      end
      if (state == S_CSUM && cnt16 == 16'd0)
        acc_q <= 20'({IP_VER_IHL, 8'h00}) + 20'(tlen) + 20'(ident_q) +
                 20'(IP_FLAGS_DF) + 20'({TTL, IP_PROTO_UDP}) +
                 20'(src_ip_q[31:16]) + 20'(src_ip_q[15:0]) +
                 20'(dst_ip_q[31:16]) + 20'(dst_ip_q[15:0]);
      if (state == S_CSUM && cnt16 == 16'd1) csum_q <= csum_fold(acc_q);
      if (state == S_GAP && state_nxt == S_IDLE) ident_q <= ident_q + 16'd1;
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Registered frame byte output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data       <= 8'h00;
      tx_data_valid <= 1'b0;
    end else begin
      tx_data       <= tx_byte;
      tx_data_valid <= tx_vld;
    end
  end

endmodule
